// File: rtl/seq_udiv8x4_pkg.sv
// -----------------------------------------------------------------------------
// seq_udiv_pkg
// Shared definitions for the seq_udiv8x4 iterative unsigned divider:
//   state_e  : controller states (IDLE, RUN, DONE)
//   DW_DEF   : default dividend / quotient width
//   VW_DEF   : default divisor / remainder width
//   CNT_W    : step-counter width for the default dividend width
//   mod3()   : mod-3 residue helper, used only when the optional residue
//              check (SEQ_UDIV_RESIDUE_CHECK_EN) is compiled in
// -----------------------------------------------------------------------------
package seq_udiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CNT_W  = $clog2(DW_DEF);

  // Residue of an unsigned value modulo 3. Callers zero-extend into 32 bits.
  function automatic logic [1:0] mod3(input logic [31:0] v);
    return 2'(v % 32'd3);
  endfunction

endpackage

// File: rtl/seq_udiv8x4_udiv_step.sv
// -----------------------------------------------------------------------------
// udiv_step
// One combinational restoring-division step.
//   r_i     [VW:0]  current partial remainder
//   q_msb_i         dividend bit being shifted into the remainder
//   d_i     [VW-1:0] divisor
//   r_o     [VW:0]  next partial remainder
//   q_bit_o         quotient bit produced by this step
// -----------------------------------------------------------------------------
module udiv_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] d_i,
  output logic [VW:0]   r_o,
  output logic          q_bit_o
);

  // The partial remainder never exceeds the divisor, so its MSB is always 0.
  // Keeping the full {R, q} in the trial value makes the compare exact even if
  // that invariant were ever broken, and the subtraction only needs the low bits.
  logic [VW+1:0] trial;
  logic [VW:0]   trial_sub;

  assign trial     = {r_i, q_msb_i};
  assign q_bit_o   = (trial >= {2'b00, d_i});
  assign trial_sub = trial[VW:0] - {1'b0, d_i};
  assign r_o       = q_bit_o ? trial_sub : trial[VW:0];

endmodule

// File: rtl/seq_udiv8x4.sv
// -----------------------------------------------------------------------------
// seq_udiv8x4
// Iterative unsigned divider, one restoring step per clock.
// DW-bit dividend / VW-bit divisor -> DW-bit quotient + VW-bit remainder.
// Accept-to-result latency is DW+1 cycles, or 1 cycle for divide-by-zero.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      operand handshake (dividend, divisor)
//   out_valid / out_ready    result handshake (quotient, remainder,
//                            div_by_zero)
//   residue_err              mod-3 consistency flag, only present when the
//                            macro SEQ_UDIV_RESIDUE_CHECK_EN is defined
//
// Divide-by-zero returns quotient = all ones, remainder = dividend[VW-1:0].
// -----------------------------------------------------------------------------
module seq_udiv8x4
  import seq_udiv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
`ifdef SEQ_UDIV_RESIDUE_CHECK_EN
  output logic          residue_err,
`endif
  output logic          div_by_zero
);

  localparam int            CW       = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  state_e        state_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          dbz_q;
  logic [DW-1:0] q_q;        // dividend shifts out the top, quotient in the bottom
  logic [VW-1:0] d_q;
  logic [VW:0]   r_q;
  logic [CW-1:0] cnt_q;

  logic [VW:0]   r_d;
  logic          q_bit_d;
  logic [DW-1:0] q_d;

  udiv_step #(.VW(VW)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[DW-1]),
    .d_i     (d_q),
    .r_o     (r_d),
    .q_bit_o (q_bit_d)
  );

  assign q_d = {q_q[DW-2:0], q_bit_d};

`ifdef SEQ_UDIV_RESIDUE_CHECK_EN
  logic [DW-1:0] a_q;        // untouched copy of the dividend for the check
  logic          res_err_q;
  logic          res_err_d;

  // Evaluated against the values about to be registered on the final step.
  assign res_err_d =
    mod3(32'(mod3(32'(q_d))) * 32'(mod3(32'(d_q))) + 32'(mod3(32'(r_d[VW-1:0]))))
    != mod3(32'(a_q));

  assign residue_err = res_err_q;
`endif

  // NOTE: all state below is sequential and uses non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
`ifdef SEQ_UDIV_RESIDUE_CHECK_EN
      a_q         <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          // in_ready is always high in IDLE, so in_valid alone is the accept.
          if (in_valid) begin
            in_ready_q <= 1'b0;
            d_q        <= divisor;
`ifdef SEQ_UDIV_RESIDUE_CHECK_EN
            a_q        <= dividend;
            res_err_q  <= 1'b0;
`endif
            if (divisor == '0) begin
              q_q         <= '1;
              r_q         <= {1'b0, dividend[VW-1:0]};
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              q_q     <= dividend;
              r_q     <= '0;
              cnt_q   <= CNT_LAST;
              state_q <= RUN;
            end
          end
        end

        RUN: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef SEQ_UDIV_RESIDUE_CHECK_EN
            res_err_q   <= res_err_d;
`endif
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        DONE: begin
          // Going to IDLE (not straight to a new accept) leaves one bubble
          // between a result handshake and the next operand handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
`ifdef SEQ_UDIV_RESIDUE_CHECK_EN
            res_err_q   <= 1'b0;
`endif
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign div_by_zero = dbz_q;
  assign quotient    = q_q;
  assign remainder   = r_q[VW-1:0];

endmodule
